ddr5_req_queue: RTL
===================

Name: ddr5_req_queue

Overview:
Synthesizable, parametrised request queue for the DDR5 controller front end. It accepts trace/CPU requests over a valid/ready handshake and buffers them in a circular FIFO of DEPTH entries. Each request's 34-bit physical address is decoded into DDR5 fields (row, column, bank, bank group, channel, byte select). The block adds per-entry age tracking, a starvation flag, flush, and rejection of illegal opcodes; the command scheduler downstream consumes entries.

Parameters:
ADDR_WIDTH, 34, physical address width; fixed mapping below requires exactly 34.
CPU_CYC_WIDTH, 64, width of the request timestamp.
CORE_WIDTH, 4, requesting core ID width.
OPN_WIDTH, 3, opcode width.
DEPTH, 16, queue entries; power of two, >=2.
AGE_WIDTH, 8, per-entry age counter width (saturating).
STARVE_LIMIT, 200, head age at or above which out_starve asserts.
ALMOST_FULL_TH, 12, count at or above which almost_full asserts.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request present
in_ready  out  1  queue can accept
in_cpu_cyc  in  CPU_CYC_WIDTH  request timestamp
in_core  in  CORE_WIDTH  core ID
in_opn  in  OPN_WIDTH  0=data read, 1=data write, 2=instr fetch
in_addr  in  ADDR_WIDTH  physical address
flush  in  1  discard all entries
out_valid  out  1  head entry valid
out_ready  in  1  scheduler takes head
out_cpu_cyc  out  CPU_CYC_WIDTH  head timestamp
out_core  out  CORE_WIDTH  head core
out_is_write  out  1  1 only for opn 1
out_row  out  16  addr[33:18]
out_col  out  10  {addr[17:12], addr[5:2]}
out_bank  out  2  addr[11:10]
out_bg  out  3  addr[9:7]
out_chan  out  1  addr[6]
out_bytesel  out  2  addr[1:0]
out_age  out  AGE_WIDTH  head age in cycles
out_starve  out  1  out_age >= STARVE_LIMIT
count  out  $clog2(DEPTH+1)  occupancy
almost_full  out  1  count >= ALMOST_FULL_TH
err_opn  out  1  one-cycle pulse: illegal opcode dropped

Behaviour:
- Reset (rst=1 at a clk edge): head=tail=0, count=0, all ages 0. Outputs: out_valid=0, count=0, almost_full=0, out_starve=0, err_opn=0, in_ready=1. Reset overrides flush and any handshake in the same cycle.
- Push: in_valid && in_ready at the edge. If in_opn <= 2, the entry is written at tail with age 0 and tail wraps modulo DEPTH. If in_opn > 2, nothing is written and err_opn=1 in the next cycle. in_ready is still honoured, so an illegal request is consumed.
- in_ready = (count < DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
- Pop: out_valid && out_ready at the edge. Head advances modulo DEPTH.
- Simultaneous push and pop when not full: count unchanged, and both pointers advance.
- Latency: a pushed entry is visible on the out_* ports one cycle after acceptance. There is no bypass when empty.
- out_valid = (count != 0). out_* fields are registered decode of the head entry and are don't-care when out_valid=0. Address decode is performed at push and the fields are stored.
- Age: every valid entry's age increments by 1 per cycle and saturates at 2^AGE_WIDTH-1. A newly written entry starts at 0.
- Flush: clears count, head and tail next cycle. A push in the same cycle is dropped, and in_ready is ignored. No err_opn is generated for a push in a flush cycle.
- Wrap-around: pointers are $clog2(DEPTH) bits and roll over naturally. count is tracked separately, so full and empty are unambiguous.
- Illegal parameters (DEPTH not a power of two, ADDR_WIDTH != 34): elaboration-time $error.

Decomposition:
- Package structures gains:
  - ddr5_addr_t: packed row[15:0], col_hi[5:0], bank[1:0], bg[2:0], chan, col_lo[3:0], bytesel[1:0]; exactly 34 bits, so casting the address to it performs the decode.
  - opn_e enum (OPN_RD=0, OPN_WR=1, OPN_IFETCH=2).
  - req_entry_t: cpu_cyc, core, is_write, ddr5_addr_t, age.
- One sub-module, ddr5_addr_decode (combinational, address to ddr5_addr_t plus 10-bit column), reused later by the scheduler. Storage, pointers and ages live in ddr5_req_queue.

Test Plan:
1. After reset, push opn=0, addr=34'h0_0004_0E81 -> next cycle out_valid=1, out_row=16'h0001, out_col=0, out_bank=3, out_bg=5, out_chan=0, out_bytesel=1, out_is_write=0, count=1.
2. Push addr=34'h3_FFFF_FFFF, opn=1 -> out_row=16'hFFFF, out_col=10'h3FF, out_bank=3, out_bg=7, out_chan=1, out_bytesel=3, out_is_write=1.
3. Push 16 entries with out_ready=0 -> count=16, in_ready=0, almost_full=1 from count 12. A 17th push is not accepted. Pop all 16 -> FIFO order preserved, including after 40 push/pop cycles that wrap the pointers.
4. Full queue, in_valid=1 and out_ready=1 in the same cycle -> pop only, count=15. Half-full queue with simultaneous push and pop -> count unchanged.
5. One entry held with out_ready=0 for 200 cycles -> out_age reaches 200 and out_starve=1. Hold until 255 -> out_age stays 255.
6. Push opn=5 -> err_opn pulses for one cycle and count is unchanged. Assert flush with 7 entries plus a concurrent push -> count=0 and out_valid=0 next cycle. Assert rst mid-traffic -> all outputs at their reset values.

Source files
------------

// File: rtl/ddr5_req_queue_pkg.sv
// Shared types for the DDR5 front-end request path: address field layout, opcodes, queue entry.
// Widths here must match the ddr5_req_queue parameters; the queue rejects mismatches at elaboration.
package ddr5_req_queue_pkg;

  localparam int ADDR_W    = 34;
  localparam int CPU_CYC_W = 64;
  localparam int CORE_W    = 4;
  localparam int OPN_W     = 3;
  localparam int AGE_W     = 8;

  typedef enum logic [OPN_W-1:0] {
    OPN_RD     = 3'd0,
    OPN_WR     = 3'd1,
    OPN_IFETCH = 3'd2
  } opn_e;

  // Field order mirrors the physical address bit order, so a cast is the decode.
  typedef struct packed {
    logic [15:0] row;
    logic [5:0]  col_hi;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic        chan;
    logic [3:0]  col_lo;
    logic [1:0]  bytesel;
  } ddr5_addr_t;

  typedef struct packed {
    logic [CPU_CYC_W-1:0] cpu_cyc;
    logic [CORE_W-1:0]    core;
    logic                 is_write;
    ddr5_addr_t           addr;
    logic [AGE_W-1:0]     age;
  } req_entry_t;

  function automatic logic opn_legal(input logic [OPN_W-1:0] opn);
    return opn <= OPN_IFETCH;
  endfunction

endpackage

// File: rtl/ddr5_addr_decode.sv
// Splits a 34-bit physical address into DDR5 fields plus the joined 10-bit column.
// Purely combinational; no handshake.
module ddr5_addr_decode
  import ddr5_req_queue_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  output ddr5_addr_t        o_fields,
  output logic [9:0]        o_col
);

  assign o_fields = ddr5_addr_t'(i_addr);
  assign o_col    = {o_fields.col_hi, o_fields.col_lo};

endmodule

// File: rtl/ddr5_req_queue.sv
// Circular request queue with per-entry aging and decoded DDR5 fields; pushed entry visible 1 cycle later.
// Backpressure: o_in_ready drops when DEPTH entries are held, even if the head is popped that cycle.
module ddr5_req_queue
  import ddr5_req_queue_pkg::*;
#(
  parameter int ADDR_WIDTH     = 34,
  parameter int CPU_CYC_WIDTH  = 64,
  parameter int CORE_WIDTH     = 4,
  parameter int OPN_WIDTH      = 3,
  parameter int DEPTH          = 16,
  parameter int AGE_WIDTH      = 8,
  parameter int STARVE_LIMIT   = 200,
  parameter int ALMOST_FULL_TH = 12
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [CPU_CYC_WIDTH-1:0]     i_in_cpu_cyc,
  input  logic [CORE_WIDTH-1:0]        i_in_core,
  input  logic [OPN_WIDTH-1:0]         i_in_opn,
  input  logic [ADDR_WIDTH-1:0]        i_in_addr,
  input  logic                         i_flush,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [CPU_CYC_WIDTH-1:0]     o_out_cpu_cyc,
  output logic [CORE_WIDTH-1:0]        o_out_core,
  output logic                         o_out_is_write,
  output logic [15:0]                  o_out_row,
  output logic [9:0]                   o_out_col,
  output logic [1:0]                   o_out_bank,
  output logic [2:0]                   o_out_bg,
  output logic                         o_out_chan,
  output logic [1:0]                   o_out_bytesel,
  output logic [AGE_WIDTH-1:0]         o_out_age,
  output logic                         o_out_starve,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_almost_full,
  output logic                         o_err_opn
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ddr5_req_queue: DEPTH must be a power of two >= 2");
  end
  if (ADDR_WIDTH != 34 || ADDR_WIDTH != ADDR_W) begin : g_bad_addr
    $error("ddr5_req_queue: ADDR_WIDTH must be 34");
  end
  if (CPU_CYC_WIDTH != CPU_CYC_W || CORE_WIDTH != CORE_W ||
      OPN_WIDTH != OPN_W || AGE_WIDTH != AGE_W) begin : g_bad_widths
    $error("ddr5_req_queue: field widths must match ddr5_req_queue_pkg");
  end

  req_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  ddr5_addr_t w_dec;
  logic [9:0] w_dec_col;
  logic       w_unused_col;
  req_entry_t w_head;
  logic       w_push_hs;
  logic       w_push;
  logic       w_pop;

  ddr5_addr_decode u_dec (
    .i_addr   (i_in_addr),
    .o_fields (w_dec),
    .o_col    (w_dec_col)
  );
  assign w_unused_col = ^w_dec_col;

  // A flush cycle swallows the request entirely, including its error report.
  assign w_push_hs = i_in_valid && o_in_ready && !i_flush;
  assign w_push    = w_push_hs && opn_legal(i_in_opn);
  assign w_pop     = o_out_valid && i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_err <= w_push_hs && !opn_legal(i_in_opn);
      // Stale slots age too; a write resets the slot, so only live entries matter.
      for (int i = 0; i < DEPTH; i++) begin
        if (r_mem[i].age != '1) r_mem[i].age <= r_mem[i].age + AGE_W'(1);
      end
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_tail] <= '{cpu_cyc:  i_in_cpu_cyc,
                             core:     i_in_core,
                             is_write: (i_in_opn == OPN_WR),
                             addr:     w_dec,
                             age:      '0};
          r_tail <= r_tail + PTR_W'(1);
        end
        if (w_pop) r_head <= r_head + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign w_head         = r_mem[r_head];
  assign o_in_ready     = r_count < CNT_W'(DEPTH);
  assign o_out_valid    = r_count != '0;
  assign o_count        = r_count;
  assign o_almost_full  = r_count >= CNT_W'(ALMOST_FULL_TH);
  assign o_err_opn      = r_err;
  assign o_out_cpu_cyc  = w_head.cpu_cyc;
  assign o_out_core     = w_head.core;
  assign o_out_is_write = w_head.is_write;
  assign o_out_row      = w_head.addr.row;
  assign o_out_col      = {w_head.addr.col_hi, w_head.addr.col_lo};
  assign o_out_bank     = w_head.addr.bank;
  assign o_out_bg       = w_head.addr.bg;
  assign o_out_chan     = w_head.addr.chan;
  assign o_out_bytesel  = w_head.addr.bytesel;
  assign o_out_age      = w_head.age;
  assign o_out_starve   = w_head.age >= AGE_W'(STARVE_LIMIT);

endmodule
